// File: rtl/contactor_sequencer.sv
// Round-robin contactor sequencer: switches one coil at a time, confirms each
// transition against the aux feedback with a timeout and reports errors.
module contactor_sequencer #(
    parameter int N_CONTACTORS   = 21,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SETTLE_CYCLES  = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CONTACTORS-1:0]   spi_requests,
    input  logic [2*N_CONTACTORS-1:0] router_feedback,
    input  logic                      force_off,
    input  logic                      clear_errors,
    output logic [N_CONTACTORS-1:0]   contactor_status,
    output logic                      busy,
    output logic                      feedback_timeout_error,
    output logic                      invalid_request,
    output logic [4:0]                fault_index
);

    localparam int IW   = 5;
    localparam int TMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(N_CONTACTORS - 1);
    localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_SETTLE  = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FB,
        SETTLE,
        FAULT
    } state_t;

    state_t            state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     idx;
    logic [TW-1:0]     timer;

    logic [N_CONTACTORS-1:0] pending;
    logic                    sel_found;
    logic [IW-1:0]           sel_idx;
    logic [1:0]              fb_pair;
    logic                    fb_match;
    logic                    close_req;

    assign pending   = spi_requests ^ contactor_status;
    assign close_req = |(spi_requests & ~contactor_status);
    assign fb_pair   = router_feedback[{idx, 1'b0} +: 2];
    assign fb_match  = contactor_status[idx] ? (fb_pair == 2'b01) : (fb_pair == 2'b10);
    assign busy      = (state != IDLE);

    // Rotating priority: scan from rr_ptr upward, wrapping past the last contactor.
    always_comb begin
        int unsigned j;
        j         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < N_CONTACTORS; k++) begin
            j = 32'(rr_ptr) + k;
            if (j >= N_CONTACTORS) j = j - N_CONTACTORS;
            if (!sel_found && pending[j[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = j[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= IDLE;
            rr_ptr                 <= '0;
            idx                    <= '0;
            timer                  <= '0;
            contactor_status       <= '0;
            feedback_timeout_error <= 1'b0;
            invalid_request        <= 1'b0;
            fault_index            <= '0;
        end else begin
            // Set wins over clear when both happen on the same edge.
            if (close_req && (force_off || state == FAULT))
                invalid_request <= 1'b1;
            else if (clear_errors)
                invalid_request <= 1'b0;

            if (force_off) begin
                contactor_status <= '0;
                timer            <= '0;
                if (state != FAULT) state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (sel_found) begin
                            contactor_status[sel_idx] <= spi_requests[sel_idx];
                            idx                       <= sel_idx;
                            timer                     <= '0;
                            state                     <= WAIT_FB;
                        end
                    end
                    WAIT_FB: begin
                        if (fb_match) begin
                            timer <= '0;
                            state <= SETTLE;
                        end else if (timer == T_TIMEOUT) begin
                            contactor_status[idx]  <= 1'b0;
                            fault_index            <= idx;
                            feedback_timeout_error <= 1'b1;
                            state                  <= FAULT;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (timer == T_SETTLE) begin
                            rr_ptr <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                            state  <= IDLE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    FAULT: begin
                        if (clear_errors) begin
                            feedback_timeout_error <= 1'b0;
                            state                  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_contactor_sequencer.sv
// Directed bench for contactor_sequencer with a delayable/stuck feedback model.
module tb_contactor_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [20:0] spi_requests = '0;
    logic [41:0] router_feedback;
    logic        force_off = 1'b0;
    logic        clear_errors = 1'b0;
    logic [20:0] contactor_status;
    logic        busy;
    logic        feedback_timeout_error;
    logic        invalid_request;
    logic [4:0]  fault_index;

    int total = 0;
    int bad   = 0;

    int          fb_delay = 0;
    logic [20:0] stuck_mask = '0;
    logic [20:0] stuck_val  = '0;
    logic [20:0] hist [1:8];
    logic [20:0] fb_view;

    always #5 clk = ~clk;

    contactor_sequencer #(
        .N_CONTACTORS(21),
        .TIMEOUT_CYCLES(100),
        .SETTLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spi_requests(spi_requests),
        .router_feedback(router_feedback),
        .force_off(force_off),
        .clear_errors(clear_errors),
        .contactor_status(contactor_status),
        .busy(busy),
        .feedback_timeout_error(feedback_timeout_error),
        .invalid_request(invalid_request),
        .fault_index(fault_index)
    );

    initial for (int k = 1; k <= 8; k++) hist[k] = '0;

    always @(posedge clk) begin
        hist[1] <= contactor_status;
        for (int k = 2; k <= 8; k++) hist[k] <= hist[k-1];
    end

    // Aux contacts follow the coil after fb_delay edges unless stuck.
    always_comb begin
        fb_view = (fb_delay == 0) ? contactor_status : hist[fb_delay];
        router_feedback = '0;
        for (int i = 0; i < 21; i++) begin
            router_feedback[2*i]   = stuck_mask[i] ? stuck_val[i] : fb_view[i];
            router_feedback[2*i+1] = ~router_feedback[2*i];
        end
    end

    task automatic check(input string tag, input logic [41:0] got, input logic [41:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        spi_requests = '0;
        force_off    = 1'b0;
        clear_errors = 1'b0;
        stuck_mask   = '0;
        stuck_val    = '0;
        fb_delay     = 0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_status", 42'(contactor_status), 42'h0);
        check("rst_busy", 42'(busy), 42'h0);
        check("rst_to_err", 42'(feedback_timeout_error), 42'h0);
        check("rst_inv", 42'(invalid_request), 42'h0);
        check("rst_fidx", 42'(fault_index), 42'h0);
        check("rst_rr", 42'(dut.rr_ptr), 42'h0);

        // Single close, feedback 5 cycles late: match on edge N+6, idle after N+10
        fb_delay     = 5;
        spi_requests = 21'h8;
        tick();
        check("single_status", 42'(contactor_status), 42'h8);
        check("single_busy0", 42'(busy), 42'h1);
        repeat (9) tick();
        check("single_busy9", 42'(busy), 42'h1);
        tick();
        check("single_busy10", 42'(busy), 42'h0);
        check("single_status10", 42'(contactor_status), 42'h8);
        check("single_err", 42'({feedback_timeout_error, invalid_request}), 42'h0);

        // Round robin from rr_ptr = 2: order 2, 20, 0 spaced 6 cycles
        do_reset();
        spi_requests = 21'h2;
        tick();
        check("rr_first", 42'(contactor_status), 42'h2);
        spi_requests = 21'h100007;
        repeat (5) tick();
        check("rr_hold", 42'(contactor_status), 42'h2);
        check("rr_ptr2", 42'(dut.rr_ptr), 42'h2);
        check("rr_idle", 42'(busy), 42'h0);
        tick();
        check("rr_c2", 42'(contactor_status), 42'h6);
        repeat (5) tick();
        check("rr_c2_hold", 42'(contactor_status), 42'h6);
        tick();
        check("rr_c20", 42'(contactor_status), 42'h100006);
        repeat (6) tick();
        check("rr_c0", 42'(contactor_status), 42'h100007);

        // Timeout on contactor 7 with feedback stuck open
        do_reset();
        stuck_mask   = 21'h80;
        stuck_val    = '0;
        spi_requests = 21'h80;
        tick();
        check("to_close", 42'(contactor_status), 42'h80);
        repeat (99) tick();
        check("to_pre_status", 42'(contactor_status), 42'h80);
        check("to_pre_err", 42'(feedback_timeout_error), 42'h0);
        tick();
        check("to_status", 42'(contactor_status), 42'h0);
        check("to_err", 42'(feedback_timeout_error), 42'h1);
        check("to_fidx", 42'(fault_index), 42'h7);
        check("to_busy", 42'(busy), 42'h1);
        spi_requests = 21'h280;
        tick();
        check("to_inv", 42'(invalid_request), 42'h1);
        check("to_ignored", 42'(contactor_status), 42'h0);
        repeat (3) tick();
        check("to_still_fault", 42'({busy, feedback_timeout_error}), 42'h3);
        stuck_mask   = '0;
        spi_requests = 21'h80;
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        check("clr_err", 42'(feedback_timeout_error), 42'h0);
        check("clr_idle", 42'(busy), 42'h0);
        check("clr_inv_set_wins", 42'(invalid_request), 42'h1);
        tick();
        check("retry7", 42'(contactor_status), 42'h80);
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        check("clr_inv", 42'(invalid_request), 42'h0);

        // force_off during WAIT_FB with three coils closed
        do_reset();
        spi_requests = 21'h7;
        tick();
        repeat (12) tick();
        check("fo_three", 42'(contactor_status), 42'h7);
        check("fo_waiting", 42'(busy), 42'h1);
        force_off = 1'b1;
        tick();
        check("fo_zero", 42'(contactor_status), 42'h0);
        check("fo_idle", 42'(busy), 42'h0);
        check("fo_inv0", 42'(invalid_request), 42'h0);
        tick();
        check("fo_inv1", 42'(invalid_request), 42'h1);
        check("fo_held", 42'(contactor_status), 42'h0);
        force_off = 1'b0;
        tick();
        check("fo_resume", 42'(contactor_status), 42'h4);

        // Request reverted during SETTLE
        do_reset();
        spi_requests = 21'h10;
        tick();
        tick();
        spi_requests = '0;
        repeat (4) tick();
        check("rev_hold", 42'(contactor_status), 42'h10);
        check("rev_idle", 42'(busy), 42'h0);
        tick();
        check("rev_open", 42'(contactor_status), 42'h0);
        check("rev_busy", 42'(busy), 42'h1);

        // Async reset between edges in WAIT_FB
        do_reset();
        spi_requests = 21'h20;
        tick();
        repeat (5) tick();
        check("ar_rr6", 42'(dut.rr_ptr), 42'h6);
        stuck_mask   = 21'h40;
        spi_requests = 21'h60;
        tick();
        check("ar_close6", 42'(contactor_status), 42'h60);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("ar_status", 42'(contactor_status), 42'h0);
        check("ar_busy", 42'(busy), 42'h0);
        check("ar_rr", 42'(dut.rr_ptr), 42'h0);
        check("ar_flags", 42'({feedback_timeout_error, invalid_request, fault_index}), 42'h0);
        tick();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
